// File: rtl/branch_checkpoint_stack.sv
// Circular stack of branch checkpoints holding free-list snapshots; restores the
// snapshot of a mispredicted branch and squashes every younger checkpoint.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

module branch_checkpoint_stack #(
    parameter int DEPTH = 4,
    parameter int PRF   = `PHYS_REG_SZ_R10K
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dispatch_valid,
    input  logic [PRF-1:0]           dispatch_free_list,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    output logic                     stack_full,
    input  logic                     resolve_valid,
    input  logic [$clog2(DEPTH)-1:0] resolve_tag,
    input  logic                     resolve_mispredict,
    input  logic [PRF-1:0]           retire_free_mask,
    output logic [PRF-1:0]           free_list_restore,
    output logic                     restore_flag,
    output logic [DEPTH-1:0]         squash_mask
);
    localparam int TW = $clog2(DEPTH);
    localparam logic [TW:0] FULL_CNT = (TW+1)'(DEPTH);

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0][PRF-1:0] snap_q, snap_d;
    logic [TW-1:0]             head_q, head_d, tail_q, tail_d;
    logic [TW:0]               count_q, count_d;
    logic [PRF-1:0]            restore_q, restore_d;
    logic                      flag_q, flag_d;
    logic [DEPTH-1:0]          squash_q, squash_d;

    logic          mispredict, correct, do_alloc, stop;
    logic [TW-1:0] off_t, off_i, idx;
    logic [TW:0]   cnt_m, skip;

    assign alloc_tag         = tail_q;
    assign stack_full        = (count_q == FULL_CNT);
    assign free_list_restore = restore_q;
    assign restore_flag      = flag_q;
    assign squash_mask       = squash_q;

    assign mispredict = resolve_valid & resolve_mispredict & valid_q[resolve_tag];
    assign correct    = resolve_valid & ~resolve_mispredict & valid_q[resolve_tag];
    assign do_alloc   = dispatch_valid & ~stack_full & ~(resolve_valid & resolve_mispredict);

    always_comb begin
        valid_d   = valid_q;
        snap_d    = snap_q;
        tail_d    = tail_q;
        cnt_m     = count_q;
        restore_d = restore_q;
        flag_d    = 1'b0;
        squash_d  = '0;
        off_t     = resolve_tag - head_q;
        off_i     = '0;
        idx       = '0;
        skip      = '0;
        stop      = 1'b0;

        // Age offsets relative to head decide which entries are younger than the mispredict.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) snap_d[i] = snap_q[i] | retire_free_mask;
            off_i = TW'(i) - head_q;
            if (mispredict && off_i >= off_t && {1'b0, off_i} < count_q) begin
                valid_d[i]  = 1'b0;
                squash_d[i] = 1'b1;
            end
        end

        if (correct) valid_d[resolve_tag] = 1'b0;

        if (mispredict) begin
            tail_d    = resolve_tag;
            cnt_m     = {1'b0, off_t};
            restore_d = snap_q[resolve_tag] | retire_free_mask;
            flag_d    = 1'b1;
        end

        if (do_alloc) begin
            snap_d[tail_q]  = dispatch_free_list | retire_free_mask;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end

        // Retire the run of already-resolved entries at the head in a single cycle.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + TW'(i);
            if (!stop && (TW+1)'(i) < cnt_m && !valid_d[idx]) skip = skip + 1'b1;
            else                                              stop = 1'b1;
        end

        head_d  = head_q + skip[TW-1:0];
        count_d = cnt_m - skip + {{TW{1'b0}}, do_alloc};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            snap_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            restore_q <= '0;
            flag_q    <= 1'b0;
            squash_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            snap_q    <= snap_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            restore_q <= restore_d;
            flag_q    <= flag_d;
            squash_q  <= squash_d;
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Bench for branch_checkpoint_stack: directed scenarios plus random traffic against
// an age-ordered queue model of live checkpoints.
module tb_branch_checkpoint_stack;
    localparam int DEPTH = 4;
    localparam int PRF   = 64;
    localparam int TW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             dispatch_valid = 1'b0;
    logic [PRF-1:0]   dispatch_free_list = '0;
    logic [TW-1:0]    alloc_tag;
    logic             stack_full;
    logic             resolve_valid = 1'b0;
    logic [TW-1:0]    resolve_tag = '0;
    logic             resolve_mispredict = 1'b0;
    logic [PRF-1:0]   retire_free_mask = '0;
    logic [PRF-1:0]   free_list_restore;
    logic             restore_flag;
    logic [DEPTH-1:0] squash_mask;

    branch_checkpoint_stack #(.DEPTH(DEPTH), .PRF(PRF)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_free_list(dispatch_free_list),
        .alloc_tag(alloc_tag), .stack_full(stack_full),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict), .retire_free_mask(retire_free_mask),
        .free_list_restore(free_list_restore), .restore_flag(restore_flag),
        .squash_mask(squash_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        int             tag;
        bit             valid;
        logic [PRF-1:0] snap;
    } ent_t;

    ent_t             q[$];
    int               m_tail;
    logic             exp_flag;
    logic [DEPTH-1:0] exp_mask;
    logic [PRF-1:0]   exp_restore;
    logic [PRF-1:0]   fill_dfl [DEPTH];
    int               n_cmp = 0;
    int               n_bad = 0;

    function automatic logic [PRF-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        q.delete();
        m_tail      = 0;
        exp_flag    = 1'b0;
        exp_mask    = '0;
        exp_restore = '0;
    endtask

    task automatic model_step(input logic dv, input logic [PRF-1:0] dfl, input logic rv,
                              input int rt, input logic rm, input logic [PRF-1:0] rmask);
        int pos;
        bit full;
        pos  = -1;
        full = (q.size() == DEPTH);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].valid) q[i].snap = q[i].snap | rmask;
            if (q[i].tag == rt) pos = i;
        end
        exp_flag = 1'b0;
        exp_mask = '0;
        if (rv && pos >= 0 && q[pos].valid) begin
            if (rm) begin
                exp_restore = q[pos].snap;
                exp_flag    = 1'b1;
                for (int j = pos; j < q.size(); j++) exp_mask[q[j].tag] = 1'b1;
                while (q.size() > pos) void'(q.pop_back());
                m_tail = rt;
            end else begin
                q[pos].valid = 1'b0;
            end
        end
        if (dv && !full && !(rv && rm)) begin
            q.push_back('{m_tail, 1'b1, dfl | rmask});
            m_tail = (m_tail + 1) % DEPTH;
        end
        while (q.size() > 0 && !q[0].valid) void'(q.pop_front());
    endtask

    // Drives one cycle of inputs at the negedge, advances the model, returns at the next negedge.
    task automatic drive(input logic dv, input logic [PRF-1:0] dfl, input logic rv,
                         input int rt, input logic rm, input logic [PRF-1:0] rmask);
        dispatch_valid     = dv;
        dispatch_free_list = dfl;
        resolve_valid      = rv;
        resolve_tag        = TW'(rt);
        resolve_mispredict = rm;
        retire_free_mask   = rmask;
        model_step(dv, dfl, rv, rt, rm, rmask);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        dispatch_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        retire_free_mask = '0; dispatch_free_list = '0; resolve_tag = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (alloc_tag !== '0) begin n_bad++; $display("FAIL reset_tag: got %0d expected 0", alloc_tag); end
        n_cmp++; if (stack_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0b expected 0", stack_full); end
        n_cmp++; if (restore_flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %0b expected 0", restore_flag); end
        n_cmp++; if (squash_mask !== '0) begin n_bad++; $display("FAIL reset_squash: got %0b expected 0", squash_mask); end
        n_cmp++; if (free_list_restore !== '0) begin n_bad++; $display("FAIL reset_restore: got %0h expected 0", free_list_restore); end
        n_cmp++; if (int'(dut.count_q) != 0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
    endtask

    task automatic test_fill();
        for (int t = 0; t < DEPTH; t++) begin
            n_cmp++; if (int'(alloc_tag) != t) begin n_bad++; $display("FAIL fill_tag: got %0d expected %0d", alloc_tag, t); end
            fill_dfl[t] = rnd64();
            drive(1'b1, fill_dfl[t], 1'b0, 0, 1'b0, '0);
        end
        n_cmp++; if (stack_full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %0b expected 1", stack_full); end
        drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        n_cmp++; if (alloc_tag !== '0) begin n_bad++; $display("FAIL fill_overflow_tail: got %0d expected 0", alloc_tag); end
        n_cmp++; if (int'(dut.count_q) != DEPTH) begin n_bad++; $display("FAIL fill_overflow_count: got %0d expected %0d", dut.count_q, DEPTH); end
    endtask

    task automatic test_mispredict();
        drive(1'b0, '0, 1'b1, 1, 1'b1, '0);
        n_cmp++; if (restore_flag !== 1'b1) begin n_bad++; $display("FAIL mp_flag: got %0b expected 1", restore_flag); end
        n_cmp++; if (squash_mask !== 4'b1110) begin n_bad++; $display("FAIL mp_squash: got %b expected 1110", squash_mask); end
        n_cmp++; if (free_list_restore !== fill_dfl[1]) begin n_bad++; $display("FAIL mp_restore: got %0h expected %0h", free_list_restore, fill_dfl[1]); end
        drive(1'b0, '0, 1'b0, 0, 1'b0, '0);
        n_cmp++; if (restore_flag !== 1'b0) begin n_bad++; $display("FAIL mp_flag_pulse: got %0b expected 0", restore_flag); end
        n_cmp++; if (squash_mask !== '0) begin n_bad++; $display("FAIL mp_squash_pulse: got %b expected 0", squash_mask); end
        n_cmp++; if (free_list_restore !== fill_dfl[1]) begin n_bad++; $display("FAIL mp_restore_hold: got %0h expected %0h", free_list_restore, fill_dfl[1]); end
        n_cmp++; if (alloc_tag !== 2'd1) begin n_bad++; $display("FAIL mp_tail: got %0d expected 1", alloc_tag); end
        n_cmp++; if (int'(dut.count_q) != 1) begin n_bad++; $display("FAIL mp_count: got %0d expected 1", dut.count_q); end
    endtask

    task automatic test_head_skip();
        apply_reset();
        repeat (3) drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1, 1'b0, '0);
        n_cmp++; if (int'(dut.head_q) != 0) begin n_bad++; $display("FAIL skip_head_hold: got %0d expected 0", dut.head_q); end
        n_cmp++; if (int'(dut.count_q) != 3) begin n_bad++; $display("FAIL skip_count_hold: got %0d expected 3", dut.count_q); end
        drive(1'b0, '0, 1'b1, 0, 1'b0, '0);
        n_cmp++; if (int'(dut.head_q) != 2) begin n_bad++; $display("FAIL skip_head: got %0d expected 2", dut.head_q); end
        n_cmp++; if (int'(dut.count_q) != 1) begin n_bad++; $display("FAIL skip_count: got %0d expected 1", dut.count_q); end
        n_cmp++; if (alloc_tag !== 2'd3) begin n_bad++; $display("FAIL skip_tail: got %0d expected 3", alloc_tag); end
    endtask

    task automatic test_retire_restore();
        logic [PRF-1:0] d;
        logic [PRF-1:0] bit7;
        apply_reset();
        bit7 = '0;
        bit7[7] = 1'b1;
        d = rnd64() & ~bit7;
        drive(1'b1, d, 1'b0, 0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 0, 1'b0, bit7);
        drive(1'b0, '0, 1'b1, 0, 1'b1, '0);
        n_cmp++; if (free_list_restore[7] !== 1'b1) begin n_bad++; $display("FAIL retire_bit7: got %0b expected 1", free_list_restore[7]); end
        n_cmp++; if (free_list_restore !== (d | bit7)) begin n_bad++; $display("FAIL retire_restore: got %0h expected %0h", free_list_restore, d | bit7); end
        n_cmp++; if (restore_flag !== 1'b1) begin n_bad++; $display("FAIL retire_flag: got %0b expected 1", restore_flag); end
    endtask

    task automatic test_dispatch_vs_mispredict();
        apply_reset();
        drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        drive(1'b1, rnd64(), 1'b1, 0, 1'b1, '0);
        n_cmp++; if (int'(dut.count_q) != 0) begin n_bad++; $display("FAIL dvm_count: got %0d expected 0", dut.count_q); end
        n_cmp++; if (restore_flag !== 1'b1) begin n_bad++; $display("FAIL dvm_flag: got %0b expected 1", restore_flag); end
        n_cmp++; if (alloc_tag !== '0) begin n_bad++; $display("FAIL dvm_tail: got %0d expected 0", alloc_tag); end
        n_cmp++; if (squash_mask !== 4'b0001) begin n_bad++; $display("FAIL dvm_squash: got %b expected 0001", squash_mask); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 0, 1'b1, '0);
        repeat (3) drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        resolve_valid = 1'b1; resolve_tag = '0; resolve_mispredict = 1'b1; dispatch_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (restore_flag !== 1'b0) begin n_bad++; $display("FAIL mid_flag: got %0b expected 0", restore_flag); end
        n_cmp++; if (squash_mask !== '0) begin n_bad++; $display("FAIL mid_squash: got %b expected 0", squash_mask); end
        n_cmp++; if (free_list_restore !== '0) begin n_bad++; $display("FAIL mid_restore: got %0h expected 0", free_list_restore); end
        n_cmp++; if (int'(dut.count_q) != 0) begin n_bad++; $display("FAIL mid_count: got %0d expected 0", dut.count_q); end
        n_cmp++; if (alloc_tag !== '0) begin n_bad++; $display("FAIL mid_tail: got %0d expected 0", alloc_tag); end
        @(posedge clock); #1;
        n_cmp++; if (restore_flag !== 1'b0) begin n_bad++; $display("FAIL mid_flag_after: got %0b expected 0", restore_flag); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        drive(1'b1, rnd64(), 1'b0, 0, 1'b0, '0);
        n_cmp++; if (alloc_tag !== 2'd1) begin n_bad++; $display("FAIL mid_first_dispatch: got %0d expected 1", alloc_tag); end
        n_cmp++; if (restore_flag !== 1'b0) begin n_bad++; $display("FAIL mid_no_pulse: got %0b expected 0", restore_flag); end
    endtask

    task automatic test_random();
        logic           dv, rv, rm;
        logic [PRF-1:0] rmask;
        int             rt;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            dv = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 1) == 1);
            rm = ($urandom_range(0, 9) < 3);
            rt = $urandom_range(0, DEPTH - 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) rt = q[$urandom_range(0, q.size() - 1)].tag;
            rmask = ($urandom_range(0, 1) == 1) ? (rnd64() & rnd64() & rnd64()) : '0;
            drive(dv, rnd64(), rv, rt, rm, rmask);
            n_cmp++; if (int'(alloc_tag) != m_tail) begin n_bad++; $display("FAIL rnd_tag @%0d: got %0d expected %0d", n, alloc_tag, m_tail); end
            n_cmp++; if (stack_full !== (q.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_full @%0d: got %0b expected %0b", n, stack_full, q.size() == DEPTH); end
            n_cmp++; if (int'(dut.count_q) != q.size()) begin n_bad++; $display("FAIL rnd_count @%0d: got %0d expected %0d", n, dut.count_q, q.size()); end
            n_cmp++; if (restore_flag !== exp_flag) begin n_bad++; $display("FAIL rnd_flag @%0d: got %0b expected %0b", n, restore_flag, exp_flag); end
            n_cmp++; if (squash_mask !== exp_mask) begin n_bad++; $display("FAIL rnd_squash @%0d: got %b expected %b", n, squash_mask, exp_mask); end
            n_cmp++; if (free_list_restore !== exp_restore) begin n_bad++; $display("FAIL rnd_restore @%0d: got %0h expected %0h", n, free_list_restore, exp_restore); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_mispredict();
        test_head_skip();
        test_retire_restore();
        test_dispatch_vs_mispredict();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_checkpoint_stack.md
BRANCH_CHECKPOINT_STACK -- requirements
Module: branch_checkpoint_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of in-flight branch checkpoints (power of two, 2..16).
REQ-002 SHALL have parameter PRF, default `PHYS_REG_SZ_R10K, the free-list width in bits.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dispatch_valid  input  1  a branch is dispatching this cycle (at most one per cycle).
REQ-006 SHALL have port dispatch_free_list  input  PRF  free-list snapshot after this branch's dispatch allocations.
REQ-007 SHALL have port alloc_tag  output  $clog2(DEPTH)  entry index the dispatching branch receives.
REQ-008 SHALL have port stack_full  output  1  no entry available; dispatch must stall branches.
REQ-009 SHALL have port resolve_valid  input  1  a branch resolves this cycle.
REQ-010 SHALL have port resolve_tag  input  $clog2(DEPTH)  tag of the resolving branch.
REQ-011 SHALL have port resolve_mispredict  input  1  the resolving branch mispredicted.
REQ-012 SHALL have port retire_free_mask  input  PRF  one-hot-per-register mask of T_old registers freed by retire this cycle.
REQ-013 SHALL have port free_list_restore  output  PRF  registered snapshot for the free list on mispredict.
REQ-014 SHALL have port restore_flag  output  1  registered one-cycle mispredict pulse to the free list.
REQ-015 SHALL have port squash_mask  output  DEPTH  registered; bit i set = tag i squashed (same cycle as restore_flag).

Function
REQ-016 SHALL store per entry: valid bit and PRF-bit snapshot; circular buffer with head (oldest), tail (next allocation) and count (0..DEPTH, $clog2(DEPTH)+1 bits).
REQ-017 SHALL drive alloc_tag = tail and stack_full = (count == DEPTH) combinationally.
REQ-018 SHALL on dispatch_valid & ~stack_full & ~(resolve_valid & resolve_mispredict): write snapshot[tail] = dispatch_free_list | retire_free_mask, set valid[tail], tail = tail+1 mod DEPTH.
REQ-019 SHALL ignore dispatch_valid while stack_full (no state change).
REQ-020 SHALL every cycle OR retire_free_mask into the snapshot of every valid entry, so snapshots never re-allocate retired registers.
REQ-021 SHALL on resolve_valid & ~resolve_mispredict with valid[resolve_tag]: clear valid[resolve_tag]; out-of-order correct resolves allowed.
REQ-022 SHALL advance head past consecutive invalid entries (up to count entries in one cycle), decrementing count by the number skipped.
REQ-023 SHALL on resolve_valid & resolve_mispredict with valid[resolve_tag]: clear valid for resolve_tag and every entry younger than it up to tail-1, set tail = resolve_tag, recompute count = (resolve_tag - head) mod DEPTH, with count=0 when resolve_tag==head.
REQ-024 SHALL on that mispredict register free_list_restore = snapshot[resolve_tag] | retire_free_mask, restore_flag = 1, squash_mask = set of squashed tags, all visible the next cycle for exactly one cycle.
REQ-025 SHALL ignore resolves naming an invalid tag (no state or output change).
REQ-026 SHALL give a same-cycle mispredict priority over dispatch; the dispatching branch is dropped and receives no entry.
REQ-027 SHALL hold restore_flag=0, squash_mask=0 in all non-mispredict cycles; free_list_restore holds its last value.
REQ-028 SHALL wrap head and tail modulo DEPTH; full and empty are distinguished by count, never by pointer equality.

Reset
REQ-029 SHALL on reset asynchronously clear all valid bits, head=tail=count=0, restore_flag=0, squash_mask=0, free_list_restore=0.
REQ-030 SHALL abandon any in-progress mispredict on reset assertion; no restore_flag pulse after reset.
REQ-031 SHALL accept dispatch on the first posedge after reset deassertion.

Verification
REQ-032 Four dispatches (DEPTH=4) -> tags 0,1,2,3, stack_full=1; fifth dispatch ignored, tail stays 0.
REQ-033 Tags 0-3 live, resolve tag 1 mispredict -> next cycle restore_flag=1, squash_mask=4'b1110, free_list_restore=snapshot[1]; then count=1, alloc_tag=1.
REQ-034 Tags 0,1,2 live, correct resolve 1 then 0 -> head jumps 0->2 in one cycle, count=1.
REQ-035 Snapshot with bit 7=0, then retire_free_mask bit 7, then mispredict on that tag -> free_list_restore bit 7=1.
REQ-036 Dispatch and mispredict on tag 0 same cycle -> no allocation, count=0, restore_flag=1 next cycle.
REQ-037 Reset asserted mid-cycle with 3 live entries -> outputs zero immediately, count=0, no restore_flag.
